// File: rtl/alarm_ring_controller.sv
// Alarm sequencer for the digital clock: arm, ring, snooze, dismiss and ring timeout.
// Build option: define RING_BLINK_EN to blink the LED at 0.5 Hz while ringing.
module alarm_ring_controller #(
  parameter int SNOOZE_MIN     = 5,
  parameter int MAX_SNOOZE     = 3,
  parameter int RING_TIMEOUT_S = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic [5:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic [5:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic       alarm_en,
  input  logic       snooze_p,
  input  logic       dismiss_p,
  output logic [1:0] state,
  output logic       ring,
  output logic [1:0] snooze_cnt,
  output logic [5:0] target_hour,
  output logic [5:0] target_min,
  output logic       missed
);

  localparam logic [1:0] ST_DISARMED = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_RINGING  = 2'd2;
  localparam logic [1:0] ST_SNOOZED  = 2'd3;

  localparam logic [1:0] SNOOZE_LIMIT = 2'(MAX_SNOOZE);
  localparam logic [7:0] TIMER_LAST   = 8'(RING_TIMEOUT_S - 1);
  localparam logic [6:0] SNOOZE_ADD   = 7'(SNOOZE_MIN);

  function automatic logic [5:0] hour_inc(input logic [5:0] h);
    return (h == 6'd23) ? 6'd0 : h + 6'd1;
  endfunction

  function automatic logic [11:0] next_minute(input logic [5:0] h, input logic [5:0] m);
    if (m == 6'd59) return {hour_inc(h), 6'd0};
    return {h, m + 6'd1};
  endfunction

  function automatic logic [11:0] snooze_time(input logic [5:0] h, input logic [5:0] m);
    logic [6:0] sum;
    sum = {1'b0, m} + SNOOZE_ADD;
    if (sum >= 7'd60) return {hour_inc(h), 6'(sum - 7'd60)};
    return {h, sum[5:0]};
  endfunction

  logic [7:0]  ring_timer;
  logic [11:0] next_hm;
  logic [11:0] snooze_hm;
  logic        match;
  logic        ring_hold;

  logic [1:0]  next_state;
  logic        next_ring;
  logic [1:0]  next_cnt;
  logic [5:0]  next_th;
  logic [5:0]  next_tm;
  logic        next_missed;
  logic [7:0]  next_timer;

  // cur_sec is the pre-increment value, so a tick at :59 lands the clock on hh:mm:00
  assign next_hm   = next_minute(cur_hour, cur_min);
  assign snooze_hm = snooze_time(cur_hour, cur_min);
  assign match     = tick_1hz && (cur_sec == 6'd59) && (next_hm == {target_hour, target_min});

`ifdef RING_BLINK_EN
  assign ring_hold = ~ring;
`else
  assign ring_hold = 1'b1;
`endif

  always_comb begin
    next_state  = state;
    next_ring   = ring;
    next_cnt    = snooze_cnt;
    next_th     = target_hour;
    next_tm     = target_min;
    next_missed = missed;
    next_timer  = ring_timer;
    if (!alarm_en) begin
      next_state  = ST_DISARMED;
      next_ring   = 1'b0;
      next_cnt    = 2'd0;
      next_missed = 1'b0;
      next_timer  = 8'd0;
      {next_th, next_tm} = {alarm_hour, alarm_min};
    end else begin
      case (state)
        ST_DISARMED: begin
          next_state = ST_ARMED;
          {next_th, next_tm} = {alarm_hour, alarm_min};
        end
        ST_ARMED: begin
          if (dismiss_p) next_missed = 1'b0;
          if (match) begin
            next_state = ST_RINGING;
            next_ring  = 1'b1;
            next_timer = 8'd0;
          end else begin
            {next_th, next_tm} = {alarm_hour, alarm_min};
          end
        end
        ST_RINGING: begin
          if (dismiss_p) begin
            next_state  = ST_ARMED;
            next_ring   = 1'b0;
            next_cnt    = 2'd0;
            next_missed = 1'b0;
            {next_th, next_tm} = {alarm_hour, alarm_min};
          end else if (snooze_p && (snooze_cnt < SNOOZE_LIMIT)) begin
            next_state = ST_SNOOZED;
            next_ring  = 1'b0;
            next_cnt   = snooze_cnt + 2'd1;
            {next_th, next_tm} = snooze_hm;
          end else if (tick_1hz) begin
            // Timeout is the lowest-priority exit; a refused snooze still lets it fire
            if (ring_timer == TIMER_LAST) begin
              next_state  = ST_ARMED;
              next_ring   = 1'b0;
              next_cnt    = 2'd0;
              next_missed = 1'b1;
              {next_th, next_tm} = {alarm_hour, alarm_min};
            end else begin
              next_timer = ring_timer + 8'd1;
              next_ring  = ring_hold;
            end
          end
        end
        default: begin
          if (dismiss_p) begin
            next_state  = ST_ARMED;
            next_cnt    = 2'd0;
            next_missed = 1'b0;
            {next_th, next_tm} = {alarm_hour, alarm_min};
          end else if (match) begin
            next_state = ST_RINGING;
            next_ring  = 1'b1;
            next_timer = 8'd0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_DISARMED;
      ring        <= 1'b0;
      snooze_cnt  <= 2'd0;
      target_hour <= 6'd0;
      target_min  <= 6'd0;
      missed      <= 1'b0;
      ring_timer  <= 8'd0;
    end else begin
      state       <= next_state;
      ring        <= next_ring;
      snooze_cnt  <= next_cnt;
      target_hour <= next_th;
      target_min  <= next_tm;
      missed      <= next_missed;
      ring_timer  <= next_timer;
    end
  end

endmodule

// File: tb/tb_alarm_ring_controller.sv
// Bench for alarm_ring_controller: directed scenarios plus random traffic against a
// minutes-of-day reference model.
module tb_alarm_ring_controller;

  localparam int SNOOZE_MIN     = 5;
  localparam int MAX_SNOOZE     = 3;
  localparam int RING_TIMEOUT_S = 60;
`ifdef RING_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic [5:0] cur_hour = 6'd0;
  logic [5:0] cur_min = 6'd0;
  logic [5:0] cur_sec = 6'd0;
  logic [5:0] alarm_hour = 6'd0;
  logic [5:0] alarm_min = 6'd0;
  logic       alarm_en = 1'b0;
  logic       snooze_p = 1'b0;
  logic       dismiss_p = 1'b0;
  logic [1:0] state;
  logic       ring;
  logic [1:0] snooze_cnt;
  logic [5:0] target_hour;
  logic [5:0] target_min;
  logic       missed;

  int checks = 0;
  int errors = 0;
  int tod = 0;

  // reference model, times kept as minutes of day
  int e_state = 0, e_ring = 0, e_cnt = 0, e_tgt = 0, e_missed = 0, e_rticks = 0;

  alarm_ring_controller #(
    .SNOOZE_MIN(SNOOZE_MIN), .MAX_SNOOZE(MAX_SNOOZE), .RING_TIMEOUT_S(RING_TIMEOUT_S)
  ) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_en(alarm_en),
    .snooze_p(snooze_p), .dismiss_p(dismiss_p),
    .state(state), .ring(ring), .snooze_cnt(snooze_cnt),
    .target_hour(target_hour), .target_min(target_min), .missed(missed)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired, simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic model_step();
    int now_min, sec, alarm_t;
    bit match;
    now_min = tod / 60;
    sec     = tod % 60;
    alarm_t = int'(alarm_hour) * 60 + int'(alarm_min);
    match   = tick_1hz && (sec == 59) && (((now_min + 1) % 1440) == e_tgt);
    if (rst) begin
      e_state = 0; e_ring = 0; e_cnt = 0; e_tgt = 0; e_missed = 0;
    end else if (!alarm_en) begin
      e_state = 0; e_ring = 0; e_cnt = 0; e_missed = 0; e_tgt = alarm_t;
    end else if (e_state == 0) begin
      e_state = 1; e_tgt = alarm_t;
    end else if (e_state == 1) begin
      if (dismiss_p) e_missed = 0;
      if (match) begin e_state = 2; e_ring = 1; e_rticks = 0; end
      else e_tgt = alarm_t;
    end else if (e_state == 2) begin
      if (dismiss_p) begin
        e_state = 1; e_ring = 0; e_cnt = 0; e_missed = 0; e_tgt = alarm_t;
      end else if (snooze_p && e_cnt < MAX_SNOOZE) begin
        e_state = 3; e_ring = 0; e_cnt++; e_tgt = (now_min + SNOOZE_MIN) % 1440;
      end else if (tick_1hz) begin
        e_rticks++;
        if (e_rticks >= RING_TIMEOUT_S) begin
          e_state = 1; e_ring = 0; e_cnt = 0; e_missed = 1; e_tgt = alarm_t;
        end else begin
          e_ring = BLINK ? int'(e_rticks % 2 == 0) : 1;
        end
      end
    end else begin
      if (dismiss_p) begin
        e_state = 1; e_cnt = 0; e_missed = 0; e_tgt = alarm_t;
      end else if (match) begin
        e_state = 2; e_ring = 1; e_rticks = 0;
      end
    end
  endtask

  task automatic cycle(input bit tk, input bit sn, input bit di);
    tick_1hz  = tk;
    snooze_p  = sn;
    dismiss_p = di;
    cur_hour  = 6'(tod / 3600);
    cur_min   = 6'((tod / 60) % 60);
    cur_sec   = 6'(tod % 60);
    model_step();
    @(posedge clk);
    #1;
    if (tk) tod = (tod + 1) % 86400;
    tick_1hz  = 1'b0;
    snooze_p  = 1'b0;
    dismiss_p = 1'b0;
  endtask

  task automatic arm(input int h, input int m);
    alarm_en = 1'b0;
    cycle(0, 0, 0);
    alarm_hour = 6'(h);
    alarm_min  = 6'(m);
    alarm_en   = 1'b1;
    cycle(0, 0, 0);
    cycle(0, 0, 0);
  endtask

  task automatic ring_at(input int h, input int m);
    tod = (h * 3600 + m * 60 - 2 + 86400) % 86400;
    cycle(1, 0, 0);
    cycle(1, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    alarm_en = 1'b0;
    alarm_hour = 6'd9;
    alarm_min = 6'd15;
    cycle(0, 0, 0);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if (ring !== 1'b0) begin errors++; $display("FAIL reset_ring got %0b want 0", ring); end
    checks++; if (snooze_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", snooze_cnt); end
    checks++; if ({target_hour, target_min} !== 12'd0) begin errors++; $display("FAIL reset_target got %0d:%0d want 0:0", target_hour, target_min); end
    checks++; if (missed !== 1'b0) begin errors++; $display("FAIL reset_missed got %0b want 0", missed); end
    rst = 1'b0;
  endtask

  task automatic test_basic_ring();
    arm(7, 30);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL basic_armed got %0d want 1", state); end
    checks++; if (target_hour !== 6'd7 || target_min !== 6'd30) begin errors++; $display("FAIL basic_target got %0d:%0d want 7:30", target_hour, target_min); end
    tod = 7 * 3600 + 29 * 60 + 55;
    for (int i = 0; i < 4; i++) cycle(1, 0, 0);
    checks++; if (state !== 2'd1 || ring !== 1'b0) begin errors++; $display("FAIL basic_early got %0d/%0b want 1/0", state, ring); end
    cycle(1, 0, 0);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL basic_ring_state got %0d want 2", state); end
    checks++; if (ring !== 1'b1) begin errors++; $display("FAIL basic_ring_led got %0b want 1", ring); end
    // LED pattern across the next three ticks
    for (int i = 1; i <= 3; i++) begin
      cycle(1, 0, 0);
      checks++;
      if (ring !== (BLINK ? 1'(i % 2 == 0) : 1'b1)) begin
        errors++; $display("FAIL blink_tick%0d got %0b want %0b", i, ring, BLINK ? 1'(i % 2 == 0) : 1'b1);
      end
    end
  endtask

  task automatic test_snooze_wrap();
    arm(23, 58);
    ring_at(23, 58);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL wrap_ring got %0d want 2", state); end
    cycle(0, 1, 0);
    checks++; if (state !== 2'd3 || ring !== 1'b0) begin errors++; $display("FAIL wrap_snoozed got %0d/%0b want 3/0", state, ring); end
    checks++; if (target_hour !== 6'd0 || target_min !== 6'd3) begin errors++; $display("FAIL wrap_target got %0d:%0d want 0:3", target_hour, target_min); end
    checks++; if (snooze_cnt !== 2'd1) begin errors++; $display("FAIL wrap_cnt got %0d want 1", snooze_cnt); end
    alarm_hour = 6'd5;
    cycle(0, 0, 0);
    checks++; if (target_hour !== 6'd0 || target_min !== 6'd3) begin errors++; $display("FAIL wrap_frozen got %0d:%0d want 0:3", target_hour, target_min); end
    alarm_hour = 6'd23;
    ring_at(0, 3);
    checks++; if (state !== 2'd2 || ring !== 1'b1) begin errors++; $display("FAIL wrap_rering got %0d/%0b want 2/1", state, ring); end
  endtask

  task automatic test_max_snooze();
    cycle(0, 1, 0);
    ring_at(0, 8);
    cycle(0, 1, 0);
    checks++; if (snooze_cnt !== 2'd3 || target_min !== 6'd13) begin errors++; $display("FAIL max_third got cnt %0d min %0d want 3 13", snooze_cnt, target_min); end
    ring_at(0, 13);
    cycle(0, 1, 0);
    checks++; if (state !== 2'd2 || ring !== 1'b1) begin errors++; $display("FAIL max_ignored got %0d/%0b want 2/1", state, ring); end
    checks++; if (snooze_cnt !== 2'd3) begin errors++; $display("FAIL max_cnt got %0d want 3", snooze_cnt); end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < RING_TIMEOUT_S - 1; i++) cycle(1, 0, 0);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL timeout_early got %0d want 2", state); end
    cycle(1, 0, 0);
    checks++; if (state !== 2'd1 || ring !== 1'b0) begin errors++; $display("FAIL timeout_state got %0d/%0b want 1/0", state, ring); end
    checks++; if (missed !== 1'b1 || snooze_cnt !== 2'd0) begin errors++; $display("FAIL timeout_missed got %0b/%0d want 1/0", missed, snooze_cnt); end
    cycle(0, 0, 1);
    checks++; if (missed !== 1'b0) begin errors++; $display("FAIL timeout_ack got %0b want 0", missed); end
    checks++; if (target_hour !== 6'd23 || target_min !== 6'd58) begin errors++; $display("FAIL timeout_target got %0d:%0d want 23:58", target_hour, target_min); end
  endtask

  task automatic test_snooze_dismiss_same();
    ring_at(23, 58);
    cycle(0, 1, 1);
    checks++; if (state !== 2'd1 || snooze_cnt !== 2'd0) begin errors++; $display("FAIL both_state got %0d/%0d want 1/0", state, snooze_cnt); end
    checks++; if (target_hour !== 6'd23 || target_min !== 6'd58 || ring !== 1'b0) begin errors++; $display("FAIL both_target got %0d:%0d ring %0b want 23:58 0", target_hour, target_min, ring); end
  endtask

  task automatic test_snoozed_dismiss_wins();
    arm(6, 0);
    ring_at(6, 0);
    cycle(0, 1, 0);
    tod = 6 * 3600 + 4 * 60 + 59;
    cycle(1, 0, 1);
    checks++; if (state !== 2'd1 || ring !== 1'b0 || snooze_cnt !== 2'd0) begin errors++; $display("FAIL snz_dismiss got %0d/%0b/%0d want 1/0/0", state, ring, snooze_cnt); end
  endtask

  task automatic test_disarm_and_rst();
    arm(23, 58);
    ring_at(23, 58);
    cycle(0, 1, 0);
    alarm_en = 1'b0;
    cycle(0, 0, 0);
    checks++; if (state !== 2'd0 || ring !== 1'b0 || snooze_cnt !== 2'd0) begin errors++; $display("FAIL disarm got %0d/%0b/%0d want 0/0/0", state, ring, snooze_cnt); end
    arm(23, 58);
    ring_at(23, 58);
    rst = 1'b1;
    cycle(0, 0, 0);
    rst = 1'b0;
    checks++; if (state !== 2'd0 || ring !== 1'b0 || snooze_cnt !== 2'd0 || missed !== 1'b0) begin errors++; $display("FAIL rst_ring got %0d/%0b/%0d/%0b want 0/0/0/0", state, ring, snooze_cnt, missed); end
    checks++; if ({target_hour, target_min} !== 12'd0) begin errors++; $display("FAIL rst_target got %0d:%0d want 0:0", target_hour, target_min); end
  endtask

  task automatic test_clock_jump();
    arm(7, 30);
    tod = 7 * 3600 + 29 * 60 + 30;
    cycle(1, 0, 0);
    tod = 7 * 3600 + 31 * 60 + 10;
    for (int i = 0; i < 5; i++) cycle(1, 0, 0);
    checks++; if (state !== 2'd1 || ring !== 1'b0) begin errors++; $display("FAIL jump got %0d/%0b want 1/0", state, ring); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      bit tk, sn, di;
      rst = ($urandom_range(0, 399) == 0);
      if (alarm_en && $urandom_range(0, 249) == 0) alarm_en = 1'b0;
      else if (!alarm_en && $urandom_range(0, 19) == 0) alarm_en = 1'b1;
      if ($urandom_range(0, 299) == 0) begin
        alarm_hour = 6'($urandom_range(0, 23));
        alarm_min  = 6'($urandom_range(0, 59));
      end
      if ($urandom_range(0, 49) == 0) tod = (e_tgt * 60 + 86400 - int'($urandom_range(1, 4))) % 86400;
      else if ($urandom_range(0, 149) == 0) tod = int'($urandom_range(0, 86399));
      tk = ($urandom_range(0, 3) != 0);
      sn = (i < 1500) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 79) == 0);
      di = (i < 1500) ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 299) == 0);
      cycle(tk, sn, di);
      checks++; if (state !== 2'(e_state)) begin errors++; $display("FAIL rnd_state cyc %0d got %0d want %0d", i, state, e_state); end
      checks++; if (ring !== 1'(e_ring)) begin errors++; $display("FAIL rnd_ring cyc %0d got %0b want %0d", i, ring, e_ring); end
      checks++; if (snooze_cnt !== 2'(e_cnt)) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d want %0d", i, snooze_cnt, e_cnt); end
      checks++; if (target_hour !== 6'(e_tgt / 60) || target_min !== 6'(e_tgt % 60)) begin errors++; $display("FAIL rnd_target cyc %0d got %0d:%0d want %0d:%0d", i, target_hour, target_min, e_tgt / 60, e_tgt % 60); end
      checks++; if (missed !== 1'(e_missed)) begin errors++; $display("FAIL rnd_missed cyc %0d got %0b want %0d", i, missed, e_missed); end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_ring();
    test_snooze_wrap();
    test_max_snooze();
    test_timeout();
    test_snooze_dismiss_same();
    test_snoozed_dismiss_wins();
    test_disarm_and_rst();
    test_clock_jump();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
